regfile_wr_sched: RTL and testbench

//  Write-port scheduler for the 16-bit register bank (one enable-gated register per entry).
//  - Shares the single register-file write port between NUM_REQ producers (ALU writeback, load return, special/PC path).
//  - Arbitration is round-robin, one winner per cycle.
//  - Stages the winner's data and address for one cycle, then drives a one-hot enable plus shared data to the bank.
//  - Flags pending writes so issue logic can detect RAW hazards.

---
 rtl/regfile_defs.sv | 17 +
 rtl/regfile_wr_sched_rr_arbiter.sv | 28 ++
 rtl/regfile_wr_sched.sv | 67 ++++++
 tb/tb_regfile_wr_sched.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_defs.sv
// Shared definitions for the register bank and its write-port scheduler.
package regfile_defs;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 8;
  localparam int ADDR_W     = 3;
  localparam int MAX_REGS   = 16;
  localparam int MAX_ADDR_W = 4;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  // Widest decode; callers truncate to their own bank size.
  function automatic logic [MAX_REGS-1:0] onehot_dec(input logic [MAX_ADDR_W-1:0] addr);
    onehot_dec       = '0;
    onehot_dec[addr] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_wr_sched_rr_arbiter.sv
// Round-robin arbiter: first set request at or above ptr, wrapping via a doubled request vector.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  input  logic               en,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   winner,
  output logic               vld
);
  logic [2*NUM_REQ-1:0] req_dbl;

  always_comb begin
    gnt     = '0;
    winner  = '0;
    vld     = 1'b0;
    req_dbl = {req, req};
    for (int i = 0; i < 2*NUM_REQ; i++) begin
      if (en && !vld && req_dbl[i] && (i >= int'(ptr))) begin
        vld    = 1'b1;
        winner = (i >= NUM_REQ) ? PTR_W'(i - NUM_REQ) : PTR_W'(i);
      end
    end
    if (vld) gnt[winner] = 1'b1;
  end
endmodule

// File: rtl/regfile_wr_sched.sv
// Shares the single register-bank write port between NUM_REQ producers with a one-cycle stage.
module regfile_wr_sched #(
  parameter int NUM_REQ  = 3,
  parameter int DATA_W   = regfile_defs::DATA_W,
  parameter int NUM_REGS = regfile_defs::NUM_REGS,
  parameter int ADDR_W   = regfile_defs::ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       reg_en,
  output logic [DATA_W-1:0]         reg_d,
  output logic [NUM_REGS-1:0]       busy_mask,
  output logic                      wr_drop
);
  import regfile_defs::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    winner;
  logic                gnt_vld;
  logic                stg_vld;
  logic [ADDR_W-1:0]   stg_addr;
  logic                addr_ok;
  logic [NUM_REGS-1:0] dec;

  // Gating enable with rst keeps gnt low for the whole reset window.
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr),
    .en     (rst & ~stall),
    .gnt    (gnt),
    .winner (winner),
    .vld    (gnt_vld)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      stg_vld  <= 1'b0;
      stg_addr <= '0;
      reg_d    <= '0;
    end else begin
      stg_vld <= gnt_vld;
      if (gnt_vld) begin
        rr_ptr   <= (int'(winner) == NUM_REQ-1) ? '0 : winner + PTR_W'(1);
        stg_addr <= req_addr[int'(winner)*ADDR_W +: ADDR_W];
        reg_d    <= req_data[int'(winner)*DATA_W +: DATA_W];
      end
    end
  end

  // Out-of-range and hard-zero targets still consume the grant but never reach the bank.
  always_comb begin
    dec       = NUM_REGS'(onehot_dec(MAX_ADDR_W'(stg_addr)));
    addr_ok   = (int'(stg_addr) < NUM_REGS) && !((ZERO_REG != 0) && (stg_addr == '0));
    reg_en    = (stg_vld && addr_ok) ? dec : '0;
    busy_mask = reg_en;
    wr_drop   = stg_vld && !addr_ok;
  end
endmodule

// File: tb/tb_regfile_wr_sched.sv
// Scoreboarded bench for regfile_wr_sched with a modelled register bank and a 6-entry variant.
module tb_regfile_wr_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  req;
  logic [8:0]  req_addr;
  logic [47:0] req_data;
  logic [2:0]  gnt;
  logic [7:0]  reg_en;
  logic [15:0] reg_d;
  logic [7:0]  busy_mask;
  logic        wr_drop;

  logic        stall6;
  logic [2:0]  req6;
  logic [8:0]  req_addr6;
  logic [47:0] req_data6;
  logic [2:0]  gnt6;
  logic [5:0]  reg_en6;
  logic [15:0] reg_d6;
  logic [5:0]  busy_mask6;
  logic        wr_drop6;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] bank [8] = '{default: 16'h0};

  typedef struct packed {
    logic [7:0]  en;
    logic        drop;
    logic [15:0] data;
  } stg_t;
  stg_t        sb [$];
  int          m_ptr = 0;
  logic [15:0] last_d = 16'h0;

  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  always #5 clk = ~clk;

  regfile_wr_sched u_dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .reg_en    (reg_en),
    .reg_d     (reg_d),
    .busy_mask (busy_mask),
    .wr_drop   (wr_drop)
  );

  regfile_wr_sched #(.NUM_REGS(6), .ADDR_W(3)) u_dut6 (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall6),
    .req       (req6),
    .req_addr  (req_addr6),
    .req_data  (req_data6),
    .gnt       (gnt6),
    .reg_en    (reg_en6),
    .reg_d     (reg_d6),
    .busy_mask (busy_mask6),
    .wr_drop   (wr_drop6)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] a, input logic [15:0] d);
    req_addr[i*3 +: 3]   = a;
    req_data[i*16 +: 16] = d;
  endtask

  always @(posedge clk) begin
    for (int a = 0; a < 8; a++)
      if (reg_en[a] === 1'b1) bank[a] <= reg_d;
  end

  // Reference arbiter + stage model; expected stage results are queued on each grant.
  always @(negedge clk) begin
    stg_t       e;
    int         win;
    int         idx;
    logic [2:0] eg;
    logic [2:0] a;
    if (!rst) begin
      sb.delete();
      m_ptr  = 0;
      last_d = 16'h0;
      check_val("sb_rst_gnt", gnt, 0);
      check_val("sb_rst_en", reg_en, 0);
      check_val("sb_rst_busy", busy_mask, 0);
      check_val("sb_rst_drop", wr_drop, 0);
      check_val("sb_rst_d", reg_d, 0);
    end else begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_val("sb_en", reg_en, e.en);
        check_val("sb_busy", busy_mask, e.en);
        check_val("sb_drop", wr_drop, e.drop);
        check_val("sb_d", reg_d, e.data);
        last_d = e.data;
      end else begin
        check_val("sb_idle_en", reg_en, 0);
        check_val("sb_idle_busy", busy_mask, 0);
        check_val("sb_idle_drop", wr_drop, 0);
        check_val("sb_idle_d", reg_d, last_d);
      end
      eg  = '0;
      win = -1;
      if (!stall) begin
        for (int k = 0; k < 3; k++) begin
          idx = (m_ptr + k) % 3;
          if (win < 0 && req[idx]) win = idx;
        end
      end
      if (win >= 0) eg[win] = 1'b1;
      check_val("sb_gnt", gnt, eg);
      if (win >= 0) begin
        a      = req_addr[win*3 +: 3];
        e.data = req_data[win*16 +: 16];
        e.drop = (a == 3'd0);
        e.en   = e.drop ? 8'h00 : (8'h01 << a);
        sb.push_back(e);
        m_ptr = (win + 1) % 3;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; stall = 1'b0; req = '0; req_addr = '0; req_data = '0;
    stall6 = 1'b0; req6 = '0; req_addr6 = '0; req_data6 = '0;
    set_req(0, 3'd1, 16'h1001);
    set_req(1, 3'd2, 16'h2002);
    set_req(2, 3'd3, 16'h3003);
    req = 3'b111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_gnt", gnt, 0);
    check_val("rst_en", reg_en, 0);
    check_val("rst_busy", busy_mask, 0);

    tick();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_val("rr_gnt", gnt, rr_exp[k]);
      tick();
    end
    req = '0;
    @(negedge clk);
    check_val("rr_lag_en", reg_en, 8'h02);

    tick();
    set_req(1, 3'd5, 16'hBEEF);
    req = 3'b010;
    @(negedge clk);
    check_val("wr_gnt", gnt, 3'b010);
    tick();
    req = '0;
    @(negedge clk);
    check_val("wr_en", reg_en, 8'h20);
    check_val("wr_d", reg_d, 16'hBEEF);
    check_val("wr_busy", busy_mask, 8'h20);
    tick();
    @(negedge clk);
    check_val("wr_q5", bank[5], 16'hBEEF);

    tick();
    set_req(0, 3'd2, 16'h1111);
    set_req(1, 3'd2, 16'h2222);
    req   = 3'b011;
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_val("stall_gnt", gnt, 0);
      check_val("stall_en", reg_en, 0);
      tick();
    end
    stall = 1'b0;
    @(negedge clk);
    check_val("cf_gnt0", gnt, 3'b001);
    tick();
    req = 3'b010;
    @(negedge clk);
    check_val("cf_gnt1", gnt, 3'b010);
    tick();
    req = '0;
    @(negedge clk);
    tick();
    @(negedge clk);
    check_val("cf_q2", bank[2], 16'h2222);

    tick();
    set_req(0, 3'd0, 16'hDEAD);
    req = 3'b001;
    @(negedge clk);
    check_val("z_gnt", gnt, 3'b001);
    tick();
    req = '0;
    @(negedge clk);
    check_val("z_en", reg_en, 0);
    check_val("z_drop", wr_drop, 1);
    tick();
    @(negedge clk);
    check_val("z_drop_clr", wr_drop, 0);

    tick();
    req_addr6[2:0]   = 3'd7;
    req_data6[15:0]  = 16'h7777;
    req6 = 3'b001;
    @(negedge clk);
    check_val("n6_gnt0", gnt6, 3'b001);
    tick();
    req_addr6[5:3]   = 3'd5;
    req_data6[31:16] = 16'h5555;
    req6 = 3'b010;
    @(negedge clk);
    check_val("n6_gnt1", gnt6, 3'b010);
    check_val("n6_oor_en", reg_en6, 0);
    check_val("n6_oor_drop", wr_drop6, 1);
    tick();
    req6 = '0;
    @(negedge clk);
    check_val("n6_en", reg_en6, 6'h20);
    check_val("n6_drop", wr_drop6, 0);
    check_val("n6_d", reg_d6, 16'h5555);

    tick();
    set_req(2, 3'd4, 16'hCAFE);
    req = 3'b100;
    @(negedge clk);
    check_val("mr_gnt", gnt, 3'b100);
    tick();
    req = '0;
    #2;
    check_val("mr_staged", reg_en, 8'h10);
    rst = 1'b0;
    #1;
    check_val("mr_async_en", reg_en, 0);
    check_val("mr_async_busy", busy_mask, 0);
    @(negedge clk);
    tick();
    @(negedge clk);
    check_val("mr_q4", bank[4], 16'h0000);
    tick();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
